// File: rtl/bm_combine_if.sv
`default_nettype none
// ============================================================================
// Module      : bm_combine_if
// Description : Input and output valid/ready bundle for the Box-Muller
//               final multiply stage.
// Revision    : 1.0  initial release
// ============================================================================
interface bm_combine_if;
  logic        in_valid;
  logic        in_ready;
  logic [16:0] f_in;       // UQ4.13 magnitude
  logic [15:0] g0_in;      // UQ1.15 |cos|
  logic        sign_in;    // 1 = negative result
  logic        out_valid;
  logic        out_ready;
  logic [15:0] x_out;      // signed Q5.11 noise sample

  // Upstream/downstream side (drives inputs, consumes results)
  modport master (
    output in_valid, f_in, g0_in, sign_in, out_ready,
    input  in_ready, out_valid, x_out
  );

  // Multiply stage side
  modport slave (
    input  in_valid, f_in, g0_in, sign_in, out_ready,
    output in_ready, out_valid, x_out
  );
endinterface
`default_nettype wire

// File: rtl/bm_combine.sv
`default_nettype none
// ============================================================================
// Module      : bm_combine
// Description : Box-Muller final multiply. x = +/- round_sat(f * g0) using a
//               16-iteration shift-add multiplier, valid/ready on both sides.
// Revision    : 1.0  initial release
// ============================================================================
module bm_combine (
  input  wire          clk,
  input  wire          rst,      // asynchronous, active-low
  bm_combine_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    ROUND = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [32:0] mcand;      // f shifted left once per iteration
  logic [15:0] mplier;     // g0 consumed LSB first
  logic [32:0] acc;        // UQ5.28 product when MUL completes
  logic [3:0]  cnt;
  logic        sign_q;
  logic [15:0] x_q;
  logic        out_valid_q;

  logic [15:0] mag_rnd;
  logic [15:0] mag_sat;
  logic [15:0] x_nxt;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.x_out     = x_q;

  // Round half up to Q.11, saturate to 0x7FFF, then apply the sign.
  // Saturating before negation keeps 0x8000 out of the output range.
  always_comb begin
    mag_rnd = {1'b0, acc[31:17]} + {15'd0, acc[16]};
    mag_sat = (acc[32] || (mag_rnd > 16'h7FFF)) ? 16'h7FFF : mag_rnd;
    x_nxt   = sign_q ? (16'd0 - mag_sat) : mag_sat;
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = MUL;
      MUL:     if (cnt == 4'd15)  state_nxt = ROUND;
      ROUND:                      state_nxt = OUT;
      OUT:     if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Datapath: capture, shift-add iterations, result register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand       <= '0;
      mplier      <= '0;
      acc         <= '0;
      cnt         <= '0;
      sign_q      <= 1'b0;
      x_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            mcand  <= {16'd0, bus.f_in};
            mplier <= bus.g0_in;
            sign_q <= bus.sign_in;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        MUL: begin
          acc    <= acc + (mplier[0] ? mcand : 33'd0);
          mcand  <= {mcand[31:0], 1'b0};
          mplier <= {1'b0, mplier[15:1]};
          cnt    <= cnt + 4'd1;
        end
        ROUND: begin
          x_q         <= x_nxt;
          out_valid_q <= 1'b1;
        end
        OUT: begin
          if (bus.out_ready) out_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bm_combine.sv
`default_nettype none
// ============================================================================
// Module      : tb_bm_combine
// Description : Directed self-checking bench for bm_combine with an
//               expected-value queue filled at input time.
// Revision    : 1.0  initial release
// ============================================================================
module tb_bm_combine;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic [15:0] sb[$];

  bm_combine_if bus();

  bm_combine dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: exact product, then round, saturate, sign
  function automatic logic [15:0] model(input logic [16:0] f, input logic [15:0] g, input logic s);
    logic [32:0] p;
    logic [15:0] m;
    p = 33'(f) * 33'(g);
    m = 16'(p[31:17]) + 16'(p[16]);
    if (p[32] || m > 16'h7FFF) m = 16'h7FFF;
    return s ? (16'd0 - m) : m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one input and hold it until accepted; leaves time at edge0+#1
  task automatic send(input logic [16:0] f, input logic [15:0] g, input logic s);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.f_in     = f;
    bus.g0_in    = g;
    bus.sign_in  = s;
    sb.push_back(model(f, g, s));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Count edges from acceptance to out_valid, then compare against queue
  task automatic wait_out(input string tag);
    int n;
    logic [15:0] e;
    n = 0;
    while (!bus.out_valid && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'd17);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk(tag, 32'(bus.x_out), 32'(e));
    end
  endtask

  // Full transaction with out_ready held high: consumed on edge 18
  task automatic run_one(input string tag, input logic [16:0] f, input logic [15:0] g, input logic s);
    bus.out_ready = 1'b1;
    send(f, g, s);
    wait_out(tag);
    @(posedge clk);
    #1;
    chk({tag, "_ov_clr"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_rdy"},    32'(bus.in_ready),  32'd1);
  endtask

  initial begin
    logic [15:0] held;
    int          seen;
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.f_in      = '0;
    bus.g0_in     = '0;
    bus.sign_in   = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_x_out",     32'(bus.x_out),     32'h0000);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    @(negedge clk);
    rst = 1'b1;

    // Directed data cases, fixed expectations checked against the model too
    chk("model_unity_pos", 32'(model(17'h02000, 16'h8000, 1'b0)), 32'h0800);
    run_one("unity_pos", 17'h02000, 16'h8000, 1'b0);
    run_one("unity_neg", 17'h02000, 16'h8000, 1'b1);
    run_one("zero_sign", 17'h02000, 16'h0000, 1'b1);
    run_one("round_up",  17'h00002, 16'h8000, 1'b0);
    run_one("round_dn",  17'h00001, 16'h8000, 1'b0);
    run_one("sat_pos",   17'h1FFFF, 16'hFFFF, 1'b0);
    run_one("sat_neg",   17'h1FFFF, 16'hFFFF, 1'b1);
    run_one("near_sat",  17'h1FFFE, 16'h7FFF, 1'b1);

    // Backpressure: output held, new input ignored
    bus.out_ready = 1'b0;
    send(17'h03000, 16'h6000, 1'b1);
    wait_out("hold");
    held = bus.x_out;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.f_in     = 17'h1FFFF;
      bus.g0_in    = 16'hFFFF;
      bus.sign_in  = 1'b0;
      @(posedge clk);
      #1;
      chk("hold_x",        32'(bus.x_out),     32'(held));
      chk("hold_valid",    32'(bus.out_valid), 32'd1);
      chk("hold_in_ready", 32'(bus.in_ready),  32'd0);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_ov",  32'(bus.out_valid), 32'd0);
    chk("release_rdy", 32'(bus.in_ready),  32'd1);
    chk("release_x",   32'(bus.x_out),     32'(held));
    seen = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    chk("ignored_input", 32'(seen), 32'd0);

    // Reset at MUL iteration 8: in-flight sample discarded
    send(17'h02000, 16'h8000, 1'b0);
    void'(sb.pop_back());
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_ov",  32'(bus.out_valid), 32'd0);
    chk("midrst_rdy", 32'(bus.in_ready),  32'd1);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    chk("midrst_no_out", 32'(seen), 32'd0);
    run_one("after_rst", 17'h05A5A, 16'h3C3C, 1'b1);

    // Random vectors
    for (int i = 0; i < 8; i++) begin
      run_one("rand", 17'($urandom), 16'($urandom), 1'($urandom));
    end

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bm_combine.md
# bm_combine

Final multiply stage of the Box-Muller AWGN generator. It takes one magnitude sample `f` (the sqrt(-2 ln u0) branch) and one `g0`/`sign` pair (the cos branch) on a valid/ready handshake. It forms the signed noise sample x = ±f·g0 with a 16-iteration shift-add multiplier, then rounds, saturates and applies the sign. The result is held on a valid/ready output port until the downstream block takes it.

## Interface
- No parameters; all widths are fixed.
- `clk`  in  1  rising-edge system clock
- `rst`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  `f_in`/`g0_in`/`sign_in` valid this cycle
- `in_ready`  out  1  block can accept an input
- `f_in`  in  17  unsigned UQ4.13 magnitude
- `g0_in`  in  16  unsigned UQ1.15 |cos| value
- `sign_in`  in  1  1 = negative result
- `out_valid`  out  1  `x_out` holds a result
- `out_ready`  in  1  downstream accepts `x_out`
- `x_out`  out  16  signed two's-complement Q5.11 noise sample

## Operation
- FSM states: IDLE, MUL, ROUND, OUT. Reset state is IDLE.
- `in_ready` = (state == IDLE), combinational. It reads 1 immediately after reset.
- IDLE: when `in_valid` is high, capture `f_in` into the 33-bit multiplicand, `g0_in` into the multiplier shift register, and `sign_in`. Clear the 33-bit accumulator, set the 4-bit iteration counter to 0, go to MUL.
- MUL, one iteration per cycle for 16 cycles. Multiplier LSB first: if the current multiplier bit is 1, accumulator += multiplicand. Then shift the multiplicand left by 1 and the multiplier right by 1. After counter value 15, go to ROUND.
- Product P[32:0] is UQ5.28 and exact; no overflow is possible in 33 bits.
- ROUND:
  - mag = P[31:17] + P[16], round half up, computed as a 16-bit sum.
  - If P[32] = 1 or mag > 0x7FFF, then mag = 0x7FFF (saturate).
  - x = sign ? −mag : mag. −0 = 0x0000. The minimum output is 0x8001; 0x8000 is never produced.
  - Register x into `x_out`, set `out_valid`, go to OUT.
- OUT: hold `x_out` and `out_valid` stable. When `out_ready` is high, clear `out_valid` and go to IDLE.
- `x_out` keeps its last value after the handshake until the next ROUND.
- Inputs that arrive while not in IDLE are ignored. Upstream must hold `in_valid` and its data until it sees `in_ready` high in the same cycle.

## Timing
- Reset values: `out_valid` = 0, `x_out` = 0x0000, FSM = IDLE (so `in_ready` = 1). All datapath registers and the counter are 0.
- Latency:
  - Input accepted on edge 0.
  - MUL occupies edges 1–16.
  - ROUND result is registered on edge 17.
  - `out_valid` is high from edge 17 onward.
- With `out_ready` held high, the output is consumed on edge 18 and `in_ready` is high again after edge 18. Sustained throughput is one sample per 19 cycles.
- `out_ready` high while `out_valid` is low has no effect.
- Reset asserted in any state, including mid-MUL or OUT:
  - all state is cleared asynchronously;
  - `out_valid` drops immediately;
  - the in-flight sample is discarded and never appears.
- There is no pipelining of a second input during MUL, ROUND or OUT.

## Test plan
- Unity, positive: `f_in`=0x02000 (1.0), `g0_in`=0x8000 (1.0), `sign_in`=0 -> `x_out`=0x0800 with `out_valid` rising 17 cycles after acceptance.
- Unity, negative: same data with `sign_in`=1 -> `x_out`=0xF800.
- Zero sign: `g0_in`=0x0000, `sign_in`=1 -> 0x0000.
- Rounding:
  - `f_in`=0x00002, `g0_in`=0x8000 -> 0x0001 (round bit set);
  - `f_in`=0x00001, `g0_in`=0x8000 -> 0x0000.
- Saturation: `f_in`=0x1FFFF, `g0_in`=0xFFFF, `sign_in`=0 -> 0x7FFF; same data with `sign_in`=1 -> 0x8001.
- Handshake and reset:
  - hold `out_ready`=0 for 10 cycles after `out_valid` -> `x_out` stable, `in_ready`=0, and a new `in_valid` is ignored;
  - release `out_ready` -> one transfer, then IDLE;
  - pulse `rst` low at MUL iteration 8 -> `out_valid` stays 0 and the next input is computed correctly.
